// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions: datapath width, default reset PC
// and the fetch sequencer state encodings.
package pc_fetch_unit_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [DATA_WIDTH-1:0] DEF_RESET_PC = '0;

    typedef enum logic [1:0] {
        FST_IDLE  = 2'd0,
        FST_FETCH = 2'd1,
        FST_WAIT  = 2'd2,
        FST_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch unit bus: BRAM read port plus the instruction
// valid/ready handshake towards the decoder.
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
);

    logic             bram_en;
    logic [WIDTH-1:0] bram_addr;
    logic [WIDTH-1:0] bram_rdata;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;

    modport master (
        output bram_en,
        output bram_addr,
        input  bram_rdata,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  bram_en,
        input  bram_addr,
        output bram_rdata,
        input  instr,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter register and fetch sequencer: reads BRAM at
// pc, waits out the read latency, hands the word to decode.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter int               READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             halt,
    input  logic [WIDTH-1:0] pc_next,
    pc_fetch_unit_if.master  bus,
    output logic [WIDTH-1:0] pc,
    output logic [1:0]       fetch_state
);

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    fetch_state_e     state;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] instr_q;
    logic             valid_q;
    logic             hs;

    assign hs = valid_q && bus.instr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FST_IDLE;
            cnt     <= '0;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                FST_IDLE: begin
                    if (run && !halt)
                        state <= FST_FETCH;
                end
                FST_FETCH: begin
                    cnt   <= CNT_INIT;
                    state <= FST_WAIT;
                end
                FST_WAIT: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        instr_q <= bus.bram_rdata;
                        valid_q <= 1'b1;
                        state   <= FST_VALID;
                    end
                end
                FST_VALID: begin
                    // halt only takes effect once the word is consumed
                    if (hs) begin
                        pc_q    <= pc_next;
                        valid_q <= 1'b0;
                        state   <= halt ? FST_IDLE : FST_FETCH;
                    end
                end
            endcase
        end
    end

    assign bus.bram_en     = (state == FST_FETCH);
    assign bus.bram_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign pc              = pc_q;
    assign fetch_state     = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Random-stimulus bench for pc_fetch_unit at READ_LAT 1 and 3
// against a transaction-timeline reference model.
module tb_pc_fetch_unit;

    localparam int LAT [2] = '{1, 3};

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        halt;
    logic        ready;
    logic        sel;
    logic [15:0] jmp;

    logic [15:0] pc_o      [2];
    logic [15:0] pc_next_i [2];
    logic [1:0]  st_o      [2];
    logic [15:0] rdata_i   [2];
    logic        en_o      [2];
    logic [15:0] addr_o    [2];
    logic [15:0] instr_o   [2];
    logic        val_o     [2];
    logic [15:0] pc1, pc3;
    logic [1:0]  st1, st3;

    logic [3:0]  enp [2];
    logic [15:0] adp [2][4];

    int          n_cmp;
    int          n_err;

    bit          mbusy  [2];
    bit          mval   [2];
    int          mk     [2];
    logic [15:0] mpc    [2];
    logic [15:0] minstr [2];

    pc_fetch_unit_if #(.WIDTH(16)) bus1 ();
    pc_fetch_unit_if #(.WIDTH(16)) bus3 ();

    pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .READ_LAT(1)) u_l1 (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .halt        (halt),
        .pc_next     (pc_next_i[0]),
        .bus         (bus1),
        .pc          (pc1),
        .fetch_state (st1)
    );

    pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .READ_LAT(3)) u_l3 (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .halt        (halt),
        .pc_next     (pc_next_i[1]),
        .bus         (bus3),
        .pc          (pc3),
        .fetch_state (st3)
    );

    assign pc_o[0]    = pc1;
    assign pc_o[1]    = pc3;
    assign st_o[0]    = st1;
    assign st_o[1]    = st3;
    assign en_o[0]    = bus1.bram_en;
    assign en_o[1]    = bus3.bram_en;
    assign addr_o[0]  = bus1.bram_addr;
    assign addr_o[1]  = bus3.bram_addr;
    assign instr_o[0] = bus1.instr;
    assign instr_o[1] = bus3.instr;
    assign val_o[0]   = bus1.instr_valid;
    assign val_o[1]   = bus3.instr_valid;

    assign bus1.instr_ready = ready;
    assign bus3.instr_ready = ready;
    assign bus1.bram_rdata  = rdata_i[0];
    assign bus3.bram_rdata  = rdata_i[1];

    assign pc_next_i[0] = sel ? jmp : pc1 + 16'd1;
    assign pc_next_i[1] = sel ? jmp : pc3 + 16'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // BRAM: data is only meaningful exactly LAT cycles after the enable
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            enp[d]    <= {enp[d][2:0], en_o[d]};
            adp[d][0] <= addr_o[d];
            for (int i = 1; i < 4; i++)
                adp[d][i] <= adp[d][i-1];
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rdata_i[d] = 16'hDEAD;
            if (enp[d][LAT[d]-1])
                rdata_i[d] = mem(adp[d][LAT[d]-1]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mbusy[d]  = 1'b0;
            mval[d]   = 1'b0;
            mk[d]     = 0;
            mpc[d]    = 16'h0000;
            minstr[d] = 16'h0000;
        end
    endtask

    task automatic check_all();
        logic [1:0] es;
        for (int d = 0; d < 2; d++) begin
            if (!mbusy[d])   es = 2'd0;
            else if (mval[d]) es = 2'd3;
            else if (mk[d] == 0) es = 2'd1;
            else es = 2'd2;
            chk($sformatf("L%0d_pc", LAT[d]), pc_o[d], mpc[d]);
            chk($sformatf("L%0d_addr", LAT[d]), addr_o[d], mpc[d]);
            chk($sformatf("L%0d_en", LAT[d]), en_o[d],
                mbusy[d] && !mval[d] && mk[d] == 0);
            chk($sformatf("L%0d_valid", LAT[d]), val_o[d], mval[d]);
            chk($sformatf("L%0d_state", LAT[d]), st_o[d], es);
            if (mval[d])
                chk($sformatf("L%0d_instr", LAT[d]), instr_o[d], minstr[d]);
        end
    endtask

    // Timeline view: a fetch started at k=0 delivers its word at k=LAT+1
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (!mbusy[d]) begin
                if (run && !halt) begin
                    mbusy[d] = 1'b1;
                    mk[d]    = 0;
                end
            end else if (!mval[d]) begin
                mk[d]++;
                if (mk[d] == LAT[d] + 1) begin
                    mval[d]   = 1'b1;
                    minstr[d] = mem(mpc[d]);
                end
            end else if (ready) begin
                mpc[d]  = sel ? jmp : mpc[d] + 16'd1;
                mval[d] = 1'b0;
                if (halt) mbusy[d] = 1'b0;
                else mk[d] = 0;
            end
        end
    endtask

    task automatic step();
        check_all();
        advance();
        @(negedge clk);
    endtask

    task automatic rnd_inputs();
        run   = $urandom_range(0, 7) != 0;
        halt  = $urandom_range(0, 5) == 0;
        ready = $urandom_range(0, 2) != 0;
        sel   = $urandom_range(0, 3) == 0;
        case ($urandom_range(0, 3))
            0:       jmp = 16'hFFFF;
            1:       jmp = 16'h0040;
            default: jmp = 16'($urandom);
        endcase
    endtask

    initial begin
        bit found;
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        run     = 1'b0;
        halt    = 1'b0;
        ready   = 1'b1;
        sel     = 1'b0;
        jmp     = 16'h0000;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            chk("rst_instr", bus1.instr, 16'h0000);
            check_all();
        end
        reset_n = 1'b1;
        repeat (5) step();

        run = 1'b1;
        repeat (12) step();

        ready = 1'b0;
        repeat (8) step();
        ready = 1'b1;
        repeat (4) step();

        sel = 1'b1;
        jmp = 16'hFFFF;
        repeat (6) step();
        sel = 1'b0;
        repeat (12) step();

        run  = 1'b1;
        halt = 1'b1;
        repeat (8) step();
        halt = 1'b0;

        for (int i = 0; i < 700; i++) begin
            rnd_inputs();
            step();
        end

        run   = 1'b1;
        halt  = 1'b0;
        ready = 1'b1;
        sel   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mbusy[1] && !mval[1] && mk[1] >= 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_found", found, 1'b1);

        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc3, 16'h0000);
        chk("mid_rst_valid", bus3.instr_valid, 1'b0);
        chk("mid_rst_en", bus3.bram_en, 1'b0);
        chk("mid_rst_state", st3, 2'd0);
        chk("mid_rst_instr", bus3.instr, 16'h0000);
        model_reset();
        #1 reset_n = 1'b1;
        run = 1'b0;
        @(negedge clk);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
